word_serializer: RTL

Framed parallel-to-serial transmitter that sits directly upstream of the shift-register stage and drives its serial `data_in` input. It accepts WIDTH-bit words over a valid/ready handshake and buffers them in a small FIFO. Each word goes out one bit per clock as a frame: start bit, data bits in index order, optional even parity, stop bit. The line idles low, so the downstream SISO/SIPO registers see the same idle-0 stimulus convention the team already verifies against.

---
 rtl/word_serializer_if.sv | 30 +++
 rtl/word_serializer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/word_serializer_if.sv
// Word handshake and serial line bundle for word_serializer.
// The source side drives words; the serializer drives ready and the framed line.
interface word_serializer_if #(
  parameter int WIDTH = 4
);
  logic [0:WIDTH-1] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             data_out;
  logic             frame_active;
  logic             done;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  data_out,
    input  frame_active,
    input  done
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output data_out,
    output frame_active,
    output done
  );
endinterface

// File: rtl/word_serializer.sv
// Framed parallel-to-serial transmitter with a small input FIFO.
// Frame: start(1), data bits index 0 first, optional even parity, stop(0).
// The line idles low; back-to-back frames follow with no idle gap.
module word_serializer #(
  parameter int WIDTH      = 4,
  parameter int PARITY_EN  = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  word_serializer_if.slave  bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [BIT_W-1:0] cnt, cnt_nxt;
  logic             line_nxt;
  logic             done_nxt;
  logic             pop;
  logic             shift;
  logic             push;

  logic [0:WIDTH-1] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [0:WIDTH-1] head;
  logic [0:WIDTH-1] shreg;
  logic             par;

  function automatic logic even_parity(input logic [0:WIDTH-1] w);
    return ^w;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign bus.in_ready = reset && (count < CNT_W'(FIFO_DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign head         = mem[rd_ptr];

  // FIFO pointers and occupancy; reset discards every buffered word
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; a full FIFO never accepts, so nothing is overwritten
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // Word shift register and parity latched from the popped word
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg <= head;
      par   <= even_parity(head);
    end else if (shift) begin
      shreg <= shreg << 1;
    end
  end

  // FSM state plus registered line outputs, driven from the next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      cnt               <= '0;
      bus.data_out      <= 1'b0;
      bus.frame_active  <= 1'b0;
      bus.done          <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      bus.data_out      <= line_nxt;
      bus.frame_active  <= (state_nxt != IDLE);
      bus.done          <= done_nxt;
    end
  end

  // Next state and next line bit; shreg[0] always holds the next data bit
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    line_nxt  = 1'b0;
    done_nxt  = 1'b0;
    pop       = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = START;
          line_nxt  = 1'b1;
        end
      end
      START: begin
        state_nxt = DATA;
        cnt_nxt   = '0;
        line_nxt  = shreg[0];
        shift     = 1'b1;
      end
      DATA: begin
        if (cnt == BIT_W'(WIDTH - 1)) begin
          if (PARITY_EN != 0) begin
            state_nxt = PARITY;
            line_nxt  = par;
          end else begin
            state_nxt = STOP;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt  = cnt + BIT_W'(1);
          line_nxt = shreg[0];
          shift    = 1'b1;
        end
      end
      PARITY: begin
        state_nxt = STOP;
        done_nxt  = 1'b1;
      end
      STOP: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = START;
          line_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
